fib_index: RTL and testbench
============================

Name: fib_index

Overview:
Inverse Fibonacci calculator. It uses the same go/done handshake and indexing as the team's Fibonacci calculator: F(1)=0, F(2)=1, F(3)=1, F(4)=2, F(5)=3, and so on.
Given an input value v, it returns the largest index n such that F(n) <= v, the value F(n), and whether v is itself a Fibonacci number.
It sits alongside the forward calculator and is used to check results or to build index lookups.

Parameters:
VALUE_WIDTH, 32, bit width of the input value and of fib_value.
INDEX_WIDTH, 6, bit width of the index output n; must be >= 2.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
go  in  1  start a computation for the current value; ignored while busy
value  in  VALUE_WIDTH  value v to invert; sampled only on an accepted go
n  out  INDEX_WIDTH  resulting index; valid while done=1
fib_value  out  VALUE_WIDTH  F(n); valid while done=1
is_fib  out  1  1 when F(n)==v
overflow  out  1  index saturated at 2^INDEX_WIDTH-1 before the search ended
done  out  1  result valid; held until next accepted go, cleared the cycle after it

Behaviour:
- Reset values: n=0, fib_value=0, is_fib=0, overflow=0, done=0; state IDLE; all internal registers 0.
- States: IDLE, STEP, CHECK, FINISH (FINISH exists only with the optional feature).
- go is accepted in IDLE, or in IDLE with done=1. Acceptance at edge 0:
  - v_r<=value; x<=0 (F(1)); y<=1 (F(2)); i<=2; done<=0; overflow<=0.
  - If value==0: next state IDLE; at edge 1, n=1, fib_value=0, is_fib=1, done=1.
  - Otherwise: state STEP.
- go held high while busy has no effect. go held high in IDLE restarts every cycle.
- STEP: sum_r <= x+y, computed VALUE_WIDTH+1 bits wide; next state CHECK.
- CHECK, stop condition: sum_r[VALUE_WIDTH]==1 or sum_r > v_r.
  - Outputs n=i, fib_value=y, is_fib=(y==v_r); done<=1; next state IDLE.
- CHECK, index exhausted: stop condition false and i == 2^INDEX_WIDTH-1.
  - Outputs n=i, fib_value=y, is_fib=(y==v_r), overflow=1, done=1; next state IDLE.
- CHECK, otherwise: x<=y; y<=sum_r[VALUE_WIDTH-1:0]; i<=i+1; next state STEP.
- Latency for v>0: done rises at edge 2+2k, where k is the number of CHECK iterations that continue. Example: v=1 gives k=1, done at edge 4, n=3.
- The value input may change freely after acceptance; only v_r is used.
- Width rule: the adder is VALUE_WIDTH+1 bits wide; its carry is a stop condition, never an overflow. overflow refers only to the index.
- Reset mid-operation returns immediately to the reset values; no result is produced.

Optional Feature:
Macro FIB_INDEX_NEAREST_EN.
- Defined: CHECK on any stop goes to FINISH instead of IDLE, and outputs are written in FINISH, adding exactly one cycle for v>0.
  - FINISH selects n=i+1, fib_value=sum_r[VALUE_WIDTH-1:0] when sum_r[VALUE_WIDTH]==0, the index is not exhausted, and (sum_r-v_r) < (v_r-y).
  - Otherwise FINISH selects n=i, fib_value=y. Ties pick the lower index.
  - is_fib=(fib_value==v_r).
  - The v=0 path and its latency are unchanged.
- Undefined: floor behaviour as described above; no FINISH state.

Decomposition:
- Package fib_pkg holds:
  - the state enum fib_index_state_t, typed logic [1:0];
  - constants FIB_FIRST_INDEX=1 and FIB_SEED_INDEX=2.
- No sub-module. A single always_ff FSM is sufficient.

Test Plan:
- VALUE_WIDTH=8, INDEX_WIDTH=6, go with value=0 -> at edge 1: done=1, n=1, fib_value=0, is_fib=1.
- Same parameters, value=13 -> n=8, fib_value=13, is_fib=1; done at edge 14; done held until next go, then low one cycle after it.
- value=100 -> n=12, fib_value=89, is_fib=0. With FIB_INDEX_NEAREST_EN and value=130 -> n=13, fib_value=144.
- value=255 -> adder carry stops the search: n=14, fib_value=233, is_fib=0, overflow=0.
- INDEX_WIDTH=3, value=200 -> n=7, fib_value=8, overflow=1, is_fib=0.
- Protocol checks:
  - value changed while busy -> result unaffected;
  - go pulsed while busy -> ignored;
  - rst asserted mid-search -> all outputs 0 immediately, then a fresh go yields the correct result.

Source files
------------

// File: rtl/fib_index_pkg.sv
// Shared types and constants for the inverse Fibonacci calculator (fib_index).
// Indexing follows the forward calculator: F(1)=0, F(2)=1, F(3)=1, ...
package fib_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STEP   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_FINISH = 2'd3
  } fib_index_state_t;

  localparam int FIB_FIRST_INDEX = 1;
  localparam int FIB_SEED_INDEX  = 2;

endpackage

// File: rtl/fib_index.sv
// Inverse Fibonacci: largest n with F(n) <= v, plus F(n), exact-hit and index-saturation flags.
// Define FIB_INDEX_NEAREST_EN to return the nearest Fibonacci number (ties low) via an extra FINISH cycle.
module fib_index
  import fib_pkg::*;
#(
  parameter int VALUE_WIDTH = 32,
  parameter int INDEX_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   go,
  input  logic [VALUE_WIDTH-1:0] value,
  output logic [INDEX_WIDTH-1:0] n,
  output logic [VALUE_WIDTH-1:0] fib_value,
  output logic                   is_fib,
  output logic                   overflow,
  output logic                   done
);

  localparam logic [INDEX_WIDTH-1:0] IDX_MAX = {INDEX_WIDTH{1'b1}};

  fib_index_state_t state_q, state_d;

  logic [VALUE_WIDTH-1:0] v_q, v_d;
  logic [VALUE_WIDTH-1:0] x_q, x_d;
  logic [VALUE_WIDTH-1:0] y_q, y_d;
  logic [VALUE_WIDTH:0]   sum_q, sum_d;
  logic [INDEX_WIDTH-1:0] i_q, i_d;
  logic                   zero_pend_q, zero_pend_d;
  logic [INDEX_WIDTH-1:0] n_q, n_d;
  logic [VALUE_WIDTH-1:0] fib_q, fib_d;
  logic                   is_fib_q, is_fib_d;
  logic                   ovf_q, ovf_d;
  logic                   done_q, done_d;

  logic accept_s;
  logic stop_s;
  logic exhaust_s;

  // The adder carry counts as "next term exceeds v", never as an overflow.
  assign accept_s  = go && (state_q == ST_IDLE);
  assign stop_s    = sum_q[VALUE_WIDTH] || (sum_q > {1'b0, v_q});
  assign exhaust_s = !stop_s && (i_q == IDX_MAX);

`ifdef FIB_INDEX_NEAREST_EN
  logic                   near_s;
  logic [INDEX_WIDTH-1:0] sel_n_s;
  logic [VALUE_WIDTH-1:0] sel_fib_s;

  // Pick the upper neighbour only when it is strictly closer and still addressable.
  assign near_s    = !sum_q[VALUE_WIDTH] && (i_q != IDX_MAX) &&
                     ((sum_q - {1'b0, v_q}) < ({1'b0, v_q} - {1'b0, y_q}));
  assign sel_n_s   = near_s ? (i_q + INDEX_WIDTH'(1)) : i_q;
  assign sel_fib_s = near_s ? sum_q[VALUE_WIDTH-1:0] : y_q;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && (value != '0)) begin
          state_d = ST_STEP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP:  state_d = ST_CHECK;
      ST_CHECK: begin
        if (stop_s || exhaust_s) begin
`ifdef FIB_INDEX_NEAREST_EN
          state_d = ST_FINISH;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          state_d = ST_STEP;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath and result next values
  always_comb begin
    v_d         = v_q;
    x_d         = x_q;
    y_d         = y_q;
    sum_d       = sum_q;
    i_d         = i_q;
    zero_pend_d = zero_pend_q;
    n_d         = n_q;
    fib_d       = fib_q;
    is_fib_d    = is_fib_q;
    ovf_d       = ovf_q;
    done_d      = done_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          v_d         = value;
          x_d         = '0;
          y_d         = VALUE_WIDTH'(1);
          i_d         = INDEX_WIDTH'(FIB_SEED_INDEX);
          zero_pend_d = (value == '0);
          ovf_d       = 1'b0;
          done_d      = 1'b0;
        end else if (zero_pend_q) begin
          // v=0 resolves without a search: F(1)=0 is an exact hit.
          zero_pend_d = 1'b0;
          n_d         = INDEX_WIDTH'(FIB_FIRST_INDEX);
          fib_d       = '0;
          is_fib_d    = 1'b1;
          done_d      = 1'b1;
        end else begin
          zero_pend_d = 1'b0;
        end
      end
      ST_STEP: sum_d = {1'b0, x_q} + {1'b0, y_q};
      ST_CHECK: begin
        if (stop_s || exhaust_s) begin
`ifndef FIB_INDEX_NEAREST_EN
          n_d      = i_q;
          fib_d    = y_q;
          is_fib_d = (y_q == v_q);
          ovf_d    = exhaust_s;
          done_d   = 1'b1;
`endif
        end else begin
          x_d = y_q;
          y_d = sum_q[VALUE_WIDTH-1:0];
          i_d = i_q + INDEX_WIDTH'(1);
        end
      end
      ST_FINISH: begin
`ifdef FIB_INDEX_NEAREST_EN
        n_d      = sel_n_s;
        fib_d    = sel_fib_s;
        is_fib_d = (sel_fib_s == v_q);
        ovf_d    = exhaust_s;
        done_d   = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      sum_q       <= '0;
      i_q         <= '0;
      zero_pend_q <= 1'b0;
      n_q         <= '0;
      fib_q       <= '0;
      is_fib_q    <= 1'b0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      v_q         <= v_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sum_q       <= sum_d;
      i_q         <= i_d;
      zero_pend_q <= zero_pend_d;
      n_q         <= n_d;
      fib_q       <= fib_d;
      is_fib_q    <= is_fib_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
    end
  end

  assign n         = n_q;
  assign fib_value = fib_q;
  assign is_fib    = is_fib_q;
  assign overflow  = ovf_q;
  assign done      = done_q;

endmodule

// File: tb/tb_fib_index.sv
// Directed, table-driven bench for fib_index (VALUE_WIDTH=8; INDEX_WIDTH=6 and 3).
// Expectations follow the build: FIB_INDEX_NEAREST_EN selects the nearest-value columns.
module tb_fib_index;

`ifdef FIB_INDEX_NEAREST_EN
  localparam int  EXTRA = 1;
  localparam bit  NEAR  = 1'b1;
`else
  localparam int  EXTRA = 0;
  localparam bit  NEAR  = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       go = 1'b0;
  logic [7:0] value = 8'd0;
  logic [5:0] n;
  logic [7:0] fib_value;
  logic       is_fib, overflow, done;

  logic       go3 = 1'b0;
  logic [7:0] value3 = 8'd0;
  logic [2:0] n3;
  logic [7:0] fib3;
  logic       is_fib3, overflow3, done3;

  fib_index #(.VALUE_WIDTH(8), .INDEX_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .go(go), .value(value), .n(n), .fib_value(fib_value),
    .is_fib(is_fib), .overflow(overflow), .done(done)
  );

  fib_index #(.VALUE_WIDTH(8), .INDEX_WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .go(go3), .value(value3), .n(n3), .fib_value(fib3),
    .is_fib(is_fib3), .overflow(overflow3), .done(done3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] v;
    int         n_fl;
    int         f_fl;
    int         n_nr;
    int         f_nr;
  } vec_t;

  vec_t vecs[8];
  int   total  = 0;
  int   passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Accepts go at the next posedge (edge 0); returns #1 after it with value scrambled.
  task automatic start8(input logic [7:0] v);
    @(negedge clk);
    go    = 1'b1;
    value = v;
    @(posedge clk);
    #1;
    go    = 1'b0;
    value = 8'($urandom);
  endtask

  task automatic wait_done8(output int edges);
    edges = 0;
    while (!done && edges < 300) begin
      @(posedge clk);
      edges++;
      #1;
    end
  endtask

  int e, exp_n, exp_f, exp_lat;

  initial begin
    vecs[0] = '{8'd0,   1,  0,   1,  0};
    vecs[1] = '{8'd1,   3,  1,   3,  1};
    vecs[2] = '{8'd4,   5,  3,   5,  3};
    vecs[3] = '{8'd7,   6,  5,   7,  8};
    vecs[4] = '{8'd13,  8,  13,  8,  13};
    vecs[5] = '{8'd100, 12, 89,  12, 89};
    vecs[6] = '{8'd130, 12, 89,  13, 144};
    vecs[7] = '{8'd255, 14, 233, 14, 233};

    #1 rst = 1'b1;
    #12;
    chk("reset_done", done, 0);
    chk("reset_n", n, 0);
    chk("reset_fib", fib_value, 0);
    chk("reset_isfib", is_fib, 0);
    chk("reset_ovf", overflow, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 8; k++) begin
      exp_n   = NEAR ? vecs[k].n_nr : vecs[k].n_fl;
      exp_f   = NEAR ? vecs[k].f_nr : vecs[k].f_fl;
      exp_lat = (vecs[k].v == 8'd0) ? 1 : 2 + 2 * (vecs[k].n_fl - 2) + EXTRA;
      start8(vecs[k].v);
      if (k > 0) chk($sformatf("done_clr_v%0d", vecs[k].v), done, 0);
      wait_done8(e);
      chk($sformatf("lat_v%0d", vecs[k].v), e, exp_lat);
      chk($sformatf("n_v%0d", vecs[k].v), n, exp_n);
      chk($sformatf("fib_v%0d", vecs[k].v), fib_value, exp_f);
      chk($sformatf("isfib_v%0d", vecs[k].v), is_fib, int'(exp_f == int'(vecs[k].v)));
      chk($sformatf("ovf_v%0d", vecs[k].v), overflow, 0);
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("hold_done_v%0d", vecs[k].v), done, 1);
      chk($sformatf("hold_n_v%0d", vecs[k].v), n, exp_n);
    end

    // go pulsed while busy must not restart or change the result
    start8(8'd100);
    e = 0;
    while (!done && e < 300) begin
      @(posedge clk);
      e++;
      #1;
      if (e == 3) begin go = 1'b1; value = 8'd5; end
      else begin go = 1'b0; end
    end
    go = 1'b0;
    chk("busy_go_lat", e, 2 + 2 * 10 + EXTRA);
    chk("busy_go_n", n, 12);
    chk("busy_go_fib", fib_value, 89);

    // asynchronous reset mid-search clears everything at once
    start8(8'd255);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_done", done, 0);
    chk("midrst_n", n, 0);
    chk("midrst_fib", fib_value, 0);
    chk("midrst_isfib", is_fib, 0);
    @(negedge clk);
    rst = 1'b0;
    start8(8'd13);
    wait_done8(e);
    chk("after_rst_lat", e, 14 + EXTRA);
    chk("after_rst_n", n, 8);
    chk("after_rst_fib", fib_value, 13);
    chk("after_rst_isfib", is_fib, 1);

    // index saturation with INDEX_WIDTH=3
    @(negedge clk);
    go3    = 1'b1;
    value3 = 8'd200;
    @(posedge clk);
    #1;
    go3    = 1'b0;
    value3 = 8'd3;
    e = 0;
    while (!done3 && e < 300) begin
      @(posedge clk);
      e++;
      #1;
    end
    chk("sat_lat", e, 12 + EXTRA);
    chk("sat_n", n3, 7);
    chk("sat_fib", fib3, 8);
    chk("sat_ovf", overflow3, 1);
    chk("sat_isfib", is_fib3, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
